sd_spi_responder: RTL and testbench

Synthesizable SPI-mode SD-card responder: the card end of the SD SPI protocol that the team's sdspihost drives. It lets the autotest flow run against an FPGA-resident "card" backed by a block-RAM port instead of a physical SD card. Supported commands: CMD0, CMD1/ACMD41, CMD16, CMD17 single-block read and CMD24 single-block write. CRC is never checked; transmitted CRC bytes are 0xFF.

---
 rtl/sd_spi_pkg.sv | 41 ++++
 rtl/sd_spi_responder_byte_if.sv | 67 ++++++
 rtl/sd_spi_responder.sv | 196 +++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared state encoding, SD command indices, token values and R1 response rule
// for the SPI-mode SD card responder.
package sd_spi_pkg;

    typedef enum logic [3:0] {
        S_CMD,
        S_NCR,
        S_R1,
        S_RD_GAP,
        S_RD_TOKEN,
        S_RD_DATA,
        S_RD_CRC,
        S_WR_TOKEN,
        S_WR_DATA,
        S_WR_CRC,
        S_WR_RESP,
        S_WR_BUSY
    } sd_state_t;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_OP      = 6'd1;
    localparam logic [5:0] CMD_SET_BLEN     = 6'd16;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;
    localparam logic [5:0] ACMD_SEND_OP     = 6'd41;

    localparam logic [7:0] TOKEN_START  = 8'hFE;
    localparam logic [7:0] DATA_RESP_OK = 8'h05;

    // R1 for a command, judged against the idle bit held before the command.
    function automatic logic [7:0] r1_value(input logic [5:0] idx, input logic idle);
        case (idx)
            CMD_GO_IDLE:                       return 8'h01;
            CMD_SEND_OP, ACMD_SEND_OP:         return 8'h00;
            CMD_SET_BLEN:                      return {7'b0, idle};
            CMD_READ_SINGLE, CMD_WRITE_SINGLE: return idle ? 8'h05 : 8'h00;
            default:                           return {5'b00000, 1'b1, 1'b0, idle};
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_responder_byte_if.sv
// SPI mode-0 byte engine: synchronizes sclk/cs/mosi into clk, shifts rx on rising
// and tx on falling sclk edges, and strobes byte_done once per received byte.
module spi_slave_byte_if (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       cs_idle
);

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt;
    logic [7:0] tx;
    logic       skip_fall;
    logic       sclk_rise;
    logic       sclk_fall;

    assign cs_idle   = cs_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
    assign miso      = tx[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q    <= 3'b000;
            cs_q      <= 2'b11;
            mosi_q    <= 2'b11;
            bit_cnt   <= 3'd0;
            rx_byte   <= 8'h00;
            tx        <= 8'hFF;
            skip_fall <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], sclk};
            cs_q      <= {cs_q[0], cs};
            mosi_q    <= {mosi_q[0], mosi};
            byte_done <= 1'b0;
            if (cs_q[1]) begin
                bit_cnt   <= 3'd0;
                tx        <= 8'hFF;
                skip_fall <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_byte <= {rx_byte[6:0], mosi_q[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                        skip_fall <= 1'b1;
                    end
                end
                // The fall right after a byte boundary keeps the freshly loaded MSB on miso.
                if (sclk_fall) skip_fall <= 1'b0;
                if (tx_load) tx <= tx_byte;
                else if (sclk_fall && !skip_fall) tx <= {tx[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// Card end of the SD SPI protocol backed by a byte-wide memory port; handles
// CMD0, CMD1/ACMD41, CMD16, CMD17 and CMD24 with CRC ignored and sent as 0xFF.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int BLOCK_BYTES    = 512,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int BUSY_BYTES     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      cs,
    input  logic                      mosi,
    output logic                      miso,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd,
    input  logic [7:0]                mem_rdata,
    output logic                      mem_we,
    output logic [7:0]                mem_wdata,
    output logic                      card_idle,
    output logic [15:0]               blocks_rd,
    output logic [15:0]               blocks_wr
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam int BLK_W = MEM_ADDR_WIDTH - IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [7:0]       BUSY_LAST = 8'(BUSY_BYTES - 1);

    sd_state_t        state;
    logic [2:0]       cmd_cnt;
    logic [5:0]       cmd_idx;
    logic [BLK_W-1:0] blk;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cnt;
    logic             rd_pend;
    logic [7:0]       rd_buf;
    logic             tx_load;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;
    logic             byte_done;
    logic             cs_idle;

    spi_slave_byte_if u_byte_if (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .tx_load   (tx_load),
        .tx_byte   (tx_byte),
        .miso      (miso),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .cs_idle   (cs_idle)
    );

    // Memory port has no back-pressure: mem_rd/mem_we are single-clk strobes,
    // read data is taken one clk after mem_rd, writes complete in their strobe clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_CMD;
            cmd_cnt   <= 3'd0;
            cmd_idx   <= 6'd0;
            blk       <= '0;
            idx       <= '0;
            cnt       <= 8'd0;
            rd_pend   <= 1'b0;
            rd_buf    <= 8'hFF;
            tx_load   <= 1'b0;
            tx_byte   <= 8'hFF;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            card_idle <= 1'b1;
            blocks_rd <= 16'd0;
            blocks_wr <= 16'd0;
        end else begin
            tx_load <= 1'b0;
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend) rd_buf <= mem_rdata;
            if (cs_idle) begin
                state   <= S_CMD;
                cmd_cnt <= 3'd0;
            end else if (byte_done) begin
                tx_load <= 1'b1;
                tx_byte <= 8'hFF;
                case (state)
                    S_CMD: begin
                        if (cmd_cnt != 3'd0 || rx_byte[7:6] == 2'b01) begin
                            if (cmd_cnt == 3'd0) cmd_idx <= rx_byte[5:0];
                            else if (cmd_cnt < 3'd5) blk <= BLK_W'({blk, rx_byte});
                            if (cmd_cnt == 3'd5) begin
                                cmd_cnt <= 3'd0;
                                state   <= S_NCR;
                            end else begin
                                cmd_cnt <= cmd_cnt + 3'd1;
                            end
                        end
                    end
                    S_NCR: begin
                        tx_byte <= r1_value(cmd_idx, card_idle);
                        state   <= S_R1;
                        if (cmd_idx == CMD_GO_IDLE) card_idle <= 1'b1;
                        else if (cmd_idx == CMD_SEND_OP || cmd_idx == ACMD_SEND_OP) card_idle <= 1'b0;
                    end
                    S_R1: begin
                        if (!card_idle && cmd_idx == CMD_READ_SINGLE) state <= S_RD_GAP;
                        else if (!card_idle && cmd_idx == CMD_WRITE_SINGLE) state <= S_WR_TOKEN;
                        else state <= S_CMD;
                    end
                    S_RD_GAP: begin
                        tx_byte  <= TOKEN_START;
                        idx      <= '0;
                        mem_rd   <= 1'b1;
                        mem_addr <= {blk, {IDX_W{1'b0}}};
                        state    <= S_RD_TOKEN;
                    end
                    S_RD_TOKEN: begin
                        tx_byte  <= rd_buf;
                        mem_rd   <= 1'b1;
                        mem_addr <= {blk, idx + IDX_W'(1)};
                        state    <= S_RD_DATA;
                    end
                    // rd_buf always holds the byte after the one on the wire.
                    S_RD_DATA: begin
                        if (idx == IDX_LAST) begin
                            cnt   <= 8'd0;
                            state <= S_RD_CRC;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            tx_byte <= rd_buf;
                            if (idx + IDX_W'(1) != IDX_LAST) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= {blk, idx + IDX_W'(2)};
                            end
                        end
                    end
                    S_RD_CRC: begin
                        if (cnt == 8'd1) begin
                            blocks_rd <= blocks_rd + 16'd1;
                            state     <= S_CMD;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_WR_TOKEN: begin
                        if (rx_byte == TOKEN_START) begin
                            idx   <= '0;
                            state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_byte;
                        mem_addr  <= {blk, idx};
                        if (idx == IDX_LAST) begin
                            cnt   <= 8'd0;
                            state <= S_WR_CRC;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    S_WR_CRC: begin
                        if (cnt == 8'd1) begin
                            tx_byte <= DATA_RESP_OK;
                            state   <= S_WR_RESP;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_WR_RESP: begin
                        tx_byte <= 8'h00;
                        cnt     <= 8'd0;
                        state   <= S_WR_BUSY;
                    end
                    S_WR_BUSY: begin
                        if (cnt == BUSY_LAST) begin
                            blocks_wr <= blocks_wr + 16'd1;
                            state     <= S_CMD;
                        end else begin
                            cnt     <= cnt + 8'd1;
                            tx_byte <= 8'h00;
                        end
                    end
                    default: state <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed-sequence bench for sd_spi_responder: an SPI host drives commands and
// blocks, and a rule-level card model predicts every response byte and memory write.
module tb_sd_spi_responder;

  localparam int BB    = 128;
  localparam int AW    = 16;
  localparam int BUSY  = 4;
  localparam int HALF  = 5;
  localparam int BLK_N = 1 << (AW - $clog2(BB));
  localparam int LOG_N = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          cs;
  logic          mosi;
  logic          miso;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          card_idle;
  logic [15:0]   blocks_rd;
  logic [15:0]   blocks_wr;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  sd_spi_responder #(
    .BLOCK_BYTES    (BB),
    .MEM_ADDR_WIDTH (AW),
    .BUSY_BYTES     (BUSY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .card_idle (card_idle),
    .blocks_rd (blocks_rd),
    .blocks_wr (blocks_wr)
  );

  // backing block RAM and bus monitor
  logic [7:0]    mem     [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr_log [0:LOG_N-1];
  logic [AW-1:0] wr_addr_log [0:LOG_N-1];
  logic [7:0]    wr_data_log [0:LOG_N-1];
  int rd_pulses = 0;
  int we_pulses = 0;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      if (rd_pulses < LOG_N) rd_addr_log[rd_pulses] = mem_addr;
      rd_pulses++;
    end
    if (mem_we) begin
      if (we_pulses < LOG_N) begin
        wr_addr_log[we_pulses] = mem_addr;
        wr_data_log[we_pulses] = mem_wdata;
      end
      we_pulses++;
    end
  end

  // reference card model
  logic m_idle = 1'b1;
  int   m_blocks_rd = 0;
  int   m_blocks_wr = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] model_r1(input int idx);
    if (idx == 0) return 8'h01;
    if (idx == 1 || idx == 41) return 8'h00;
    if (idx == 16) return m_idle ? 8'h01 : 8'h00;
    if (idx == 17 || idx == 24) return m_idle ? 8'h05 : 8'h00;
    return m_idle ? 8'h05 : 8'h04;
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk  = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk  = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] r;
    spi_xfer(tx, r);
  endtask

  task automatic xfer_chk(input logic [7:0] tx, input logic [7:0] exp, input string tag);
    logic [7:0] r;
    spi_xfer(tx, r);
    check(tag, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic send_cmd(input int idx, input logic [31:0] arg);
    logic [5:0] i6;
    i6 = idx[5:0];
    xfer({2'b01, i6});
    xfer(arg[31:24]);
    xfer(arg[23:16]);
    xfer(arg[15:8]);
    xfer(arg[7:0]);
    xfer(8'h95);
  endtask

  // command with no data phase; also used for CMD17/CMD24 while idle
  task automatic simple_cmd(input int idx, input logic [31:0] arg, input string tag);
    logic [7:0] r1;
    send_cmd(idx, arg);
    xfer_chk(8'hFF, 8'hFF, "ncr_fill");
    r1 = model_r1(idx);
    if (idx == 0) m_idle = 1'b1;
    else if (idx == 1 || idx == 41) m_idle = 1'b0;
    xfer_chk(8'hFF, r1, tag);
    check("card_idle", {31'd0, card_idle}, {31'd0, m_idle});
  endtask

  task automatic read_block(input int blk);
    int rd_base;
    rd_base = rd_pulses;
    send_cmd(17, blk);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int i = 0; i < BB; i++) exp_q.push_back(ref_mem[blk*BB + i]);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    while (exp_q.size() > 0) xfer_chk(8'hFF, exp_q.pop_front(), "rd_stream");
    m_blocks_rd++;
    check("rd_pulses", rd_pulses - rd_base, BB);
    check("rd_first_addr", {16'd0, rd_addr_log[rd_base]}, blk*BB);
    check("blocks_rd", {16'd0, blocks_rd}, m_blocks_rd);
  endtask

  // write n_data bytes of a block; a short count drops cs mid-block
  task automatic write_block(input int blk, input int n_data, input logic fixed, input logic [7:0] fill);
    int we_base;
    logic [7:0] d;
    we_base = we_pulses;
    send_cmd(24, blk);
    xfer_chk(8'hFF, 8'hFF, "wr_ncr");
    xfer_chk(8'hFF, 8'h00, "wr_r1");
    xfer_chk(8'hFF, 8'hFF, "wr_token_wait");
    xfer(8'hFE);
    for (int i = 0; i < n_data; i++) begin
      d = fixed ? fill : 8'($urandom_range(0, 255));
      ref_mem[blk*BB + i] = d;
      exp_q.push_back(d);
      xfer(d);
    end
    if (n_data == BB) begin
      xfer(8'h12);
      xfer(8'h34);
      xfer_chk(8'hFF, 8'h05, "wr_resp");
      for (int i = 0; i < BUSY; i++) xfer_chk(8'hFF, 8'h00, "wr_busy");
      xfer_chk(8'hFF, 8'hFF, "wr_after_busy");
      m_blocks_wr++;
    end else begin
      repeat (20) @(negedge clk);
      cs = 1'b1;
      repeat (20) @(negedge clk);
      cs = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("we_pulses", we_pulses - we_base, n_data);
    for (int i = 0; i < n_data; i++) begin
      d = exp_q.pop_front();
      check("wr_addr", {16'd0, wr_addr_log[we_base + i]}, blk*BB + i);
      check("wr_data", {24'd0, wr_data_log[we_base + i]}, {24'd0, d});
    end
    check("blocks_wr", {16'd0, blocks_wr}, m_blocks_wr);
  endtask

  initial begin
    int rd_base;
    int we_base;
    int pblk;
    int ridx;
    rst  = 1'b0;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 1);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", {16'd0, mem_addr}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_card_idle", {31'd0, card_idle}, 1);
    check("rst_blocks_rd", {16'd0, blocks_rd}, 0);
    check("rst_blocks_wr", {16'd0, blocks_wr}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("cs_high_miso", {31'd0, miso}, 1);
    cs = 1'b0;
    repeat (5) @(negedge clk);

    simple_cmd(0, 32'h0, "cmd0_r1");

    rd_base = rd_pulses;
    simple_cmd(17, 32'h0, "cmd17_idle_r1");
    xfer_chk(8'hFF, 8'hFF, "cmd17_idle_tail");
    check("cmd17_idle_no_rd", rd_pulses - rd_base, 0);

    simple_cmd(1, 32'h0, "cmd1_r1");

    for (int i = 0; i < BB; i++) begin
      mem[3*BB + i]     = 8'($urandom_range(0, 255));
      ref_mem[3*BB + i] = mem[3*BB + i];
    end
    read_block(3);

    write_block(2, BB, 1'b1, 8'hA5);

    pblk = $urandom_range(4, BLK_N - 1);
    for (int i = 0; i < BB; i++) begin
      mem[pblk*BB + i]     = 8'($urandom_range(0, 255));
      ref_mem[pblk*BB + i] = mem[pblk*BB + i];
    end
    write_block(pblk, 100, 1'b0, 8'h00);
    simple_cmd(0, 32'h0, "cmd0_after_abort");
    check("abort_blocks_wr", {16'd0, blocks_wr}, m_blocks_wr);

    simple_cmd(41, 32'h0, "acmd41_r1");
    read_block(pblk);

    xfer_chk(8'hFF, 8'hFF, "garbage_ff");
    xfer_chk(8'h3F, 8'hFF, "garbage_3f");
    simple_cmd(16, 32'd512, "cmd16_ready_r1");
    simple_cmd(5, 32'h0, "cmd5_ready_r1");

    for (int k = 0; k < 6; k++) begin
      ridx = $urandom_range(0, 63);
      if (ridx == 17 || ridx == 24) ridx = 16;
      simple_cmd(ridx, $urandom, "rand_cmd_r1");
    end

    simple_cmd(0, 32'h0, "cmd0_final");
    simple_cmd(16, 32'd512, "cmd16_idle_r1");
    we_base = we_pulses;
    simple_cmd(24, 32'd2, "cmd24_idle_r1");
    xfer_chk(8'hFE, 8'hFF, "cmd24_idle_tail");
    check("cmd24_idle_no_we", we_pulses - we_base, 0);
    check("final_blocks_rd", {16'd0, blocks_rd}, m_blocks_rd);
    check("final_blocks_wr", {16'd0, blocks_wr}, m_blocks_wr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
